// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 / stride-2 max pooling layer.
package pool_pkg;

  localparam int DEF_D_WIDTH      = 16;
  localparam int DEF_CHANNELS     = 5;
  localparam int DEF_IMAGE_WIDTH  = 60;
  localparam int DEF_IMAGE_HEIGHT = 28;

  localparam int POOL_SIZE   = 2;
  localparam int POOL_STRIDE = 2;

  typedef logic signed [DEF_D_WIDTH-1:0] sample_t;
  typedef sample_t [DEF_CHANNELS-1:0]    pixel_t;

  // Pooled pixels per frame; odd trailing rows/columns are dropped.
  function automatic int out_pixels(input int w, input int h);
    return (w / POOL_SIZE) * (h / POOL_SIZE);
  endfunction

endpackage

// File: rtl/channel_max.sv
// Per-lane signed maximum of two packed pixels; ties return the shared value.
module channel_max #(
  parameter int D_WIDTH  = 16,
  parameter int CHANNELS = 5
) (
  input  logic [CHANNELS*D_WIDTH-1:0] i_a,
  input  logic [CHANNELS*D_WIDTH-1:0] i_b,
  output logic [CHANNELS*D_WIDTH-1:0] o_max
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic signed [D_WIDTH-1:0] w_a;
    logic signed [D_WIDTH-1:0] w_b;
    assign w_a = i_a[c*D_WIDTH +: D_WIDTH];
    assign w_b = i_b[c*D_WIDTH +: D_WIDTH];
    assign o_max[c*D_WIDTH +: D_WIDTH] = (w_a >= w_b) ? w_a : w_b;
  end

endmodule

// File: rtl/max_pooling_layer.sv
// 2x2 stride-2 max pooling over a valid-qualified raster stream: a horizontal
// pair register, a half-width line buffer for the top row, and a registered output.
module max_pooling_layer
  import pool_pkg::*;
#(
  parameter int D_WIDTH      = DEF_D_WIDTH,
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic [CHANNELS*D_WIDTH-1:0]  input_data,
  input  logic                         input_valid,
  output logic [CHANNELS*D_WIDTH-1:0]  output_data,
  output logic                         valid,
  output logic                         frame_done
);

  localparam int PW       = CHANNELS * D_WIDTH;
  localparam int COL_W    = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int LB_DEPTH = (IMAGE_WIDTH / POOL_SIZE > 0) ? IMAGE_WIDTH / POOL_SIZE : 1;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [PW-1:0]    r_hreg;
  logic [PW-1:0]    r_line_buf [LB_DEPTH];
  logic [PW-1:0]    r_out_data;
  logic             r_valid;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic [LB_AW-1:0] w_lb_idx;
  logic [PW-1:0]    w_lb_rd;
  logic [PW-1:0]    w_hmax;
  logic [PW-1:0]    w_vmax;

  assign w_accept   = clk_en & input_valid;
  assign w_col_last = (r_col == COL_W'(IMAGE_WIDTH - 1));
  assign w_row_last = (r_row == ROW_W'(IMAGE_HEIGHT - 1));
  assign w_lb_idx   = LB_AW'(r_col >> 1);
  assign w_lb_rd    = r_line_buf[w_lb_idx];

  channel_max #(.D_WIDTH(D_WIDTH), .CHANNELS(CHANNELS)) u_hmax (
    .i_a   (r_hreg),
    .i_b   (input_data),
    .o_max (w_hmax)
  );

  channel_max #(.D_WIDTH(D_WIDTH), .CHANNELS(CHANNELS)) u_vmax (
    .i_a   (w_hmax),
    .i_b   (w_lb_rd),
    .o_max (w_vmax)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out_data   <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clk_en) begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      if (input_valid) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        // Odd row, odd col closes a window; the trailing odd row/col never does.
        if (r_col[0] && r_row[0]) begin
          r_out_data <= w_vmax;
          r_valid    <= 1'b1;
        end
        r_frame_done <= w_col_last && w_row_last;
      end
    end
  end

  // NOTE: datapath storage is not reset; its contents are rewritten before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (!r_col[0]) begin
        r_hreg <= input_data;
      end else if (!r_row[0]) begin
        r_line_buf[w_lb_idx] <= w_hmax;
      end
    end
  end

  assign output_data = r_out_data;
  assign valid       = r_valid;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_max_pooling_layer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares whenever a pooled pixel or frame_done is consumed.
module tb_max_pooling_layer;
  import pool_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        v;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [31:0] a_data, b_data;
  logic        a_in_v, b_in_v;
  logic [31:0] a_out, b_out;
  logic        a_v, b_v, a_fd, b_fd;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_checks = 0;
  int   n_errors = 0;
  int   a_pulses = 0;
  int   b_pulses = 0;
  int   b_frames = 0;
  int   p0;
  int   out_pos[4] = '{5, 7, 13, 15};

  logic [31:0] ramp[16];
  logic [31:0] ramp_ex[4];
  logic [31:0] neg_pix[16];
  logic [31:0] neg_ex[4];
  logic [31:0] mix_pix[16];
  logic [31:0] mix_ex[4];

  always #5 clk = ~clk;

  max_pooling_layer #(.D_WIDTH(16), .CHANNELS(2), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) dut_a (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .input_data(a_data), .input_valid(a_in_v),
    .output_data(a_out), .valid(a_v), .frame_done(a_fd)
  );

  max_pooling_layer #(.D_WIDTH(16), .CHANNELS(2), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5)) dut_b (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .input_data(b_data), .input_valid(b_in_v),
    .output_data(b_out), .valid(b_v), .frame_done(b_fd)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic v, input logic fd);
    q_a.push_back('{data: d, v: v, fd: fd});
  endtask

  task automatic push_b(input logic [31:0] d, input logic v, input logic fd);
    q_b.push_back('{data: d, v: v, fd: fd});
  endtask

  task automatic cycle_a(input logic [31:0] d, input logic v, input logic en);
    a_data = d; a_in_v = v; b_in_v = 1'b0; clk_en = en;
    @(posedge clk); #1;
  endtask

  task automatic cycle_b(input logic [31:0] d, input logic v, input logic en);
    b_data = d; b_in_v = v; a_in_v = 1'b0; clk_en = en;
    @(posedge clk); #1;
  endtask

  // One 4x4 frame into dut_a; windows close on pixels 5, 7, 13, 15.
  task automatic frame_a(input logic [31:0] pix[16], input logic [31:0] ex[4],
                         input bit gaps, input int freeze_at);
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      if (k < 4 && i == out_pos[k]) begin
        push_a(ex[k], 1'b1, i == 15);
        k++;
      end
      cycle_a(pix[i], 1'b1, 1'b1);
      if (i == freeze_at) begin
        repeat (3) cycle_a(32'h7777_7777, 1'b1, 1'b0);
        check("freeze_valid", 64'(a_v), 64'(1));
        check("freeze_data", 64'(a_out), 64'(32'h0005_0005));
        check("freeze_frame_done", 64'(a_fd), 64'(0));
      end
      if (gaps) cycle_a(32'hDEAD_BEEF, 1'b0, 1'b1);
    end
    repeat (2) cycle_a('0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!reset && clk_en) begin
      if (a_v || a_fd) begin
        if (q_a.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL a_unexpected: got valid=%0b frame_done=%0b data=%h, required no output", a_v, a_fd, a_out);
        end else begin
          e_a = q_a.pop_front();
          check("a_valid", 64'(a_v), 64'(e_a.v));
          check("a_frame_done", 64'(a_fd), 64'(e_a.fd));
          if (e_a.v) check("a_data", 64'(a_out), 64'(e_a.data));
        end
        if (a_v) a_pulses++;
      end
      if (b_v || b_fd) begin
        if (q_b.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL b_unexpected: got valid=%0b frame_done=%0b data=%h, required no output", b_v, b_fd, b_out);
        end else begin
          e_b = q_b.pop_front();
          check("b_valid", 64'(b_v), 64'(e_b.v));
          check("b_frame_done", 64'(b_fd), 64'(e_b.fd));
          if (e_b.v) check("b_data", 64'(b_out), 64'(e_b.data));
        end
        if (b_v) b_pulses++;
        if (b_fd) b_frames++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[i]    = {16'(i), 16'(i)};
      neg_pix[i] = 32'hFFFF_FFFF;
    end
    ramp_ex    = '{32'h0005_0005, 32'h0007_0007, 32'h000D_000D, 32'h000F_000F};
    neg_pix[9]  = 32'hFFFF_8000;
    neg_pix[12] = 32'h8000_FFFF;
    neg_ex     = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    mix_pix = '{32'h0001_FFFD, 32'hFFFF_0002, 32'h8000_0005, 32'h8001_0005,
                32'hFFFE_8000, 32'h0000_7FFF, 32'h8002_0005, 32'h8003_0005,
                32'h1234_FFFF, 32'hF234_FFFE, 32'h7FFE_0000, 32'h7FFF_FFFF,
                32'h0234_FFFB, 32'h8234_FFF9, 32'h7FFF_8000, 32'h0000_8000};
    mix_ex  = '{32'h0001_7FFF, 32'h8003_0005, 32'h1234_FFFF, 32'h7FFF_0000};

    reset = 1'b1; clk_en = 1'b1;
    a_data = '0; b_data = '0; a_in_v = 1'b0; b_in_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 64'({a_v, a_fd, a_out}), 64'(0));
    check("reset_b", 64'({b_v, b_fd, b_out}), 64'(0));
    reset = 1'b0;

    p0 = a_pulses; frame_a(ramp, ramp_ex, 1'b0, -1);
    check("ramp_pulses", 64'(a_pulses - p0), 64'(out_pixels(4, 4)));

    p0 = a_pulses; frame_a(neg_pix, neg_ex, 1'b0, -1);
    check("signed_pulses", 64'(a_pulses - p0), 64'(4));

    p0 = a_pulses; frame_a(mix_pix, mix_ex, 1'b0, -1);
    check("mixed_pulses", 64'(a_pulses - p0), 64'(4));

    p0 = a_pulses; frame_a(ramp, ramp_ex, 1'b1, -1);
    check("gap_pulses", 64'(a_pulses - p0), 64'(4));

    p0 = a_pulses; frame_a(ramp, ramp_ex, 1'b0, 5);
    check("freeze_pulses", 64'(a_pulses - p0), 64'(4));

    for (int i = 0; i < 6; i++) cycle_a(ramp[i], 1'b1, 1'b1);
    reset = 1'b1;
    cycle_a(ramp[6], 1'b1, 1'b0);
    reset = 1'b0;
    check("reset_mid_valid", 64'(a_v), 64'(0));
    check("reset_mid_state", 64'({a_fd, a_out}), 64'(0));
    p0 = a_pulses; frame_a(ramp, ramp_ex, 1'b0, -1);
    check("after_reset_pulses", 64'(a_pulses - p0), 64'(4));

    p0 = b_pulses;
    for (int i = 0; i < 25; i++) begin
      if (i == 6)  push_b(32'h0006_0006, 1'b1, 1'b0);
      if (i == 8)  push_b(32'h0008_0008, 1'b1, 1'b0);
      if (i == 16) push_b(32'h0010_0010, 1'b1, 1'b0);
      if (i == 18) push_b(32'h0012_0012, 1'b1, 1'b0);
      if (i == 24) push_b(32'h0000_0000, 1'b0, 1'b1);
      cycle_b({16'(i), 16'(i)}, 1'b1, 1'b1);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 6) push_b(32'h0006_0006, 1'b1, 1'b0);
      cycle_b({16'(i), 16'(i)}, 1'b1, 1'b1);
    end
    repeat (2) cycle_b('0, 1'b0, 1'b1);
    check("odd_pulses", 64'(b_pulses - p0), 64'(out_pixels(5, 5) + 1));
    check("odd_frames", 64'(b_frames), 64'(1));

    check("a_queue_empty", 64'(q_a.size()), 64'(0));
    check("b_queue_empty", 64'(q_b.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
